sel_mux_stage: RTL

Parametrised registered N:1 data selector with a valid/ready handshake and a 2-entry skid buffer. It generalises the datapath 2:1 select into a pipeline-stage element: it picks one of NUM_IN W-bit operands per transaction, registers the result, and tolerates downstream back-pressure without dropping data. It is used between pipeline stages wherever a select must not combinationally chain into the next stage, such as destination-register select or writeback-source select.

---
 rtl/mips_pkg.sv | 17 +
 rtl/skid_buf.sv | 76 +++++++
 rtl/sel_mux_stage.sv | 55 +++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared items for the datapath select stages: occupancy encoding and
// the select-width helper.
package mips_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    // A select port is never narrower than one bit, even for a 1- or 2-way select.
    function automatic int clog2_floor1(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-slot valid/ready buffer: MAIN drives the outputs, SKID absorbs one stall.
// Latency: 1 cycle from accept to out_vld.
// Backpressure: in_rdy is a flop, low only when both slots are full or the cycle after flush/reset.
module skid_buf #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    import mips_pkg::*;

    occ_t         state;
    logic [W-1:0] main_dat;
    logic [W-1:0] skid_dat;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_vld & in_rdy;
    assign out_fire = out_vld & out_rdy;
    assign out_dat  = main_dat;

    always_ff @(posedge clk) begin
        // Reset and flush leave identical state; any fire in this cycle is dropped.
        if (!rst_n || flush) begin
            state    <= OCC_EMPTY;
            main_dat <= '0;
            skid_dat <= '0;
            in_rdy   <= 1'b0;
            out_vld  <= 1'b0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    in_rdy <= 1'b1;
                    if (in_fire) begin
                        main_dat <= in_dat;
                        out_vld  <= 1'b1;
                        state    <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    in_rdy <= 1'b1;
                    if (in_fire && !out_fire) begin
                        skid_dat <= in_dat;
                        in_rdy   <= 1'b0;
                        state    <= OCC_FULL;
                    end else if (in_fire) begin
                        main_dat <= in_dat;
                    end else if (out_fire) begin
                        out_vld <= 1'b0;
                        state   <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        main_dat <= skid_dat;
                        in_rdy   <= 1'b1;
                        state    <= OCC_ONE;
                    end
                end
                default: begin
                    out_vld <= 1'b0;
                    in_rdy  <= 1'b0;
                    state   <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/sel_mux_stage.sv
// Registered N:1 operand select with error flag for out-of-range sel.
// Latency: 1 cycle (accept at edge k, out_valid from edge k).
// Backpressure: 2-entry skid, in_ready registered and independent of out_ready.
module sel_mux_stage
    import mips_pkg::*;
#(
    parameter  int W      = 5,
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = clog2_floor1(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  sel,
    input  logic [NUM_IN*W-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      dout,
    output logic              out_sel_err
);

    logic [W-1:0] sel_dat;
    logic         sel_err;
    logic [W:0]   out_dat;

    // Codes past NUM_IN-1 (possible when NUM_IN is not a power of two) fall through to the error entry.
    always_comb begin
        sel_dat = '0;
        sel_err = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_dat = din[i*W +: W];
                sel_err = 1'b0;
            end
        end
    end

    skid_buf #(.W(W + 1)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  ({sel_err, sel_dat}),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (out_dat)
    );

    assign dout        = out_dat[W-1:0];
    assign out_sel_err = out_dat[W];

endmodule
